// File: rtl/dual_pe_mem_pkg.sv
// Shared definitions for the dual-PE data memory request controller.
// Holds the memory geometry, the request bundle, the arbitration priority
// encoding and the address decode helpers used by the top level.
package dual_pe_mem_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Names the PE that wins the next same-word conflict.
  typedef enum logic {
    PRIO_PE1 = 1'b0,
    PRIO_PE2 = 1'b1
  } prio_t;

  // Misaligned or beyond the last byte of the memory.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= ADDR_W'(4 * DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W+1:2];
  endfunction

endpackage

// File: rtl/dual_pe_mem_ctrl_rsp_slot.sv
// One-entry registered response slot for a single PE.
// Ports:
//   clk, rst          clock, async active-low reset
//   load_i            request accepted this cycle; capture rdata_i/err_i
//   rdata_i, err_i    response payload to capture
//   rsp_ready_i       PE consumes the current response
//   slot_free_o       slot can take a new response at the next edge
//   rsp_valid_o, rsp_rdata_o, rsp_err_o   registered response to the PE
module pe_rsp_slot
  import dual_pe_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              err_i,
  input  logic              rsp_ready_i,
  output logic              slot_free_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  // A response being consumed this cycle frees the slot for a same-cycle reload.
  assign slot_free_o = !valid_q || rsp_ready_i;

  always_comb begin
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (load_i) begin
      valid_d = 1'b1;
      rdata_d = rdata_i;
      err_d   = err_i;
    end else if (rsp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: rtl/dual_pe_mem_ctrl.sv
// Request-side controller for the dual-ported 1024 x 32 data memory shared
// by PE1 and PE2. Checks alignment/range, drives both memory ports, and
// serializes same-word accesses involving a store with round-robin priority.
// Data width and depth come from dual_pe_mem_pkg.
// Ports:
//   clk, rst                         clock, async active-low reset
//   peN_req_valid/ready/we/addr/wdata  request handshake per PE
//   peN_rsp_valid/ready/rdata/err      registered response per PE
//   mem_weN/mem_aN/mem_wdN/mem_rdN     memory port N (word address)
//   conflict_cnt                     saturating count of serialized conflicts
//
// prio_q | meaning
// -------+-----------------------------------------
// PE1    | PE1 wins the next same-word conflict
// PE2    | PE2 wins the next same-word conflict
module dual_pe_mem_ctrl
  import dual_pe_mem_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe1_req_valid,
  output logic              pe1_req_ready,
  input  logic              pe1_req_we,
  input  logic [ADDR_W-1:0] pe1_req_addr,
  input  logic [DATA_W-1:0] pe1_req_wdata,
  output logic              pe1_rsp_valid,
  input  logic              pe1_rsp_ready,
  output logic [DATA_W-1:0] pe1_rsp_rdata,
  output logic              pe1_rsp_err,
  input  logic              pe2_req_valid,
  output logic              pe2_req_ready,
  input  logic              pe2_req_we,
  input  logic [ADDR_W-1:0] pe2_req_addr,
  input  logic [DATA_W-1:0] pe2_req_wdata,
  output logic              pe2_rsp_valid,
  input  logic              pe2_rsp_ready,
  output logic [DATA_W-1:0] pe2_rsp_rdata,
  output logic              pe2_rsp_err,
  output logic              mem_we1,
  output logic [ADDR_W-1:0] mem_a1,
  output logic [DATA_W-1:0] mem_wd1,
  input  logic [DATA_W-1:0] mem_rd1,
  output logic              mem_we2,
  output logic [ADDR_W-1:0] mem_a2,
  output logic [DATA_W-1:0] mem_wd2,
  input  logic [DATA_W-1:0] mem_rd2,
  output logic [CNT_W-1:0]  conflict_cnt
);

  mem_req_t         req1, req2;
  logic             err1, err2;
  logic [IDX_W-1:0] idx1, idx2;
  logic             free1, free2;
  logic             conflict;
  logic             acc1, acc2;
  logic [DATA_W-1:0] ld1, ld2;

  prio_t            prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign req1 = '{we: pe1_req_we, addr: pe1_req_addr, wdata: pe1_req_wdata};
  assign req2 = '{we: pe2_req_we, addr: pe2_req_addr, wdata: pe2_req_wdata};

  assign err1 = addr_err(req1.addr);
  assign err2 = addr_err(req2.addr);
  assign idx1 = word_idx(req1.addr);
  assign idx2 = word_idx(req2.addr);

  // Error requests never touch memory, so they cannot collide with anything.
  assign conflict = pe1_req_valid && pe2_req_valid && free1 && free2 &&
                    !err1 && !err2 && (idx1 == idx2) && (req1.we || req2.we);

  assign pe1_req_ready = rst && free1 && !(conflict && prio_q == PRIO_PE2);
  assign pe2_req_ready = rst && free2 && !(conflict && prio_q == PRIO_PE1);

  assign acc1 = pe1_req_valid && pe1_req_ready;
  assign acc2 = pe2_req_valid && pe2_req_ready;

  assign mem_we1 = acc1 && req1.we && !err1;
  assign mem_we2 = acc2 && req2.we && !err2;
  assign mem_a1  = pe1_req_valid ? {{(ADDR_W-IDX_W){1'b0}}, idx1} : '0;
  assign mem_a2  = pe2_req_valid ? {{(ADDR_W-IDX_W){1'b0}}, idx2} : '0;
  assign mem_wd1 = req1.wdata;
  assign mem_wd2 = req2.wdata;

  assign ld1 = (!req1.we && !err1) ? mem_rd1 : '0;
  assign ld2 = (!req2.we && !err2) ? mem_rd2 : '0;

  always_comb begin
    prio_d = prio_q;
    cnt_d  = cnt_q;
    if (conflict) begin
      // Hand the next conflict to the PE that just lost.
      prio_d = (prio_q == PRIO_PE1) ? PRIO_PE2 : PRIO_PE1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= PRIO_PE1;
      cnt_q  <= '0;
    end else begin
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;

  pe_rsp_slot u_slot1 (
    .clk         (clk),
    .rst         (rst),
    .load_i      (acc1),
    .rdata_i     (ld1),
    .err_i       (err1),
    .rsp_ready_i (pe1_rsp_ready),
    .slot_free_o (free1),
    .rsp_valid_o (pe1_rsp_valid),
    .rsp_rdata_o (pe1_rsp_rdata),
    .rsp_err_o   (pe1_rsp_err)
  );

  pe_rsp_slot u_slot2 (
    .clk         (clk),
    .rst         (rst),
    .load_i      (acc2),
    .rdata_i     (ld2),
    .err_i       (err2),
    .rsp_ready_i (pe2_rsp_ready),
    .slot_free_o (free2),
    .rsp_valid_o (pe2_rsp_valid),
    .rsp_rdata_o (pe2_rsp_rdata),
    .rsp_err_o   (pe2_rsp_err)
  );

endmodule

// File: tb/tb_dual_pe_mem_ctrl.sv
module tb_dual_pe_mem_ctrl;

  logic        clk, rst;
  logic        pe1_req_valid, pe1_req_ready, pe1_req_we;
  logic [31:0] pe1_req_addr, pe1_req_wdata;
  logic        pe1_rsp_valid, pe1_rsp_ready, pe1_rsp_err;
  logic [31:0] pe1_rsp_rdata;
  logic        pe2_req_valid, pe2_req_ready, pe2_req_we;
  logic [31:0] pe2_req_addr, pe2_req_wdata;
  logic        pe2_rsp_valid, pe2_rsp_ready, pe2_rsp_err;
  logic [31:0] pe2_rsp_rdata;
  logic        mem_we1, mem_we2;
  logic [31:0] mem_a1, mem_a2, mem_wd1, mem_wd2, mem_rd1, mem_rd2;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  dual_pe_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .pe1_req_valid(pe1_req_valid), .pe1_req_ready(pe1_req_ready), .pe1_req_we(pe1_req_we),
    .pe1_req_addr(pe1_req_addr), .pe1_req_wdata(pe1_req_wdata),
    .pe1_rsp_valid(pe1_rsp_valid), .pe1_rsp_ready(pe1_rsp_ready),
    .pe1_rsp_rdata(pe1_rsp_rdata), .pe1_rsp_err(pe1_rsp_err),
    .pe2_req_valid(pe2_req_valid), .pe2_req_ready(pe2_req_ready), .pe2_req_we(pe2_req_we),
    .pe2_req_addr(pe2_req_addr), .pe2_req_wdata(pe2_req_wdata),
    .pe2_rsp_valid(pe2_rsp_valid), .pe2_rsp_ready(pe2_rsp_ready),
    .pe2_rsp_rdata(pe2_rsp_rdata), .pe2_rsp_err(pe2_rsp_err),
    .mem_we1(mem_we1), .mem_a1(mem_a1), .mem_wd1(mem_wd1), .mem_rd1(mem_rd1),
    .mem_we2(mem_we2), .mem_a2(mem_a2), .mem_wd2(mem_wd2), .mem_rd2(mem_rd2),
    .conflict_cnt(conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The dual-ported memory itself: combinational read, write at the edge.
  logic [31:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    forever begin
      @(posedge clk);
      if (mem_we1) mem[mem_a1[9:0]] <= mem_wd1;
      if (mem_we2) mem[mem_a2[9:0]] <= mem_wd2;
    end
  end
  assign mem_rd1 = mem[mem_a1[9:0]];
  assign mem_rd2 = mem[mem_a2[9:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: golden memory contents, per-PE response slot, priority, count.
  logic [31:0] gold [1024];
  logic        m_v [2];
  logic [31:0] m_d [2];
  logic        m_e [2];
  int          m_prio, m_cnt;
  logic        v [2], we [2], rr [2], e [2], fr [2], rdy [2], acc [2], conf;
  logic [31:0] ad [2], wd [2];
  int          w [2];
  logic        a_rdy [2], a_we [2], a_rv [2], a_re [2];
  logic [31:0] a_a [2], a_wd [2], a_rd [2];

  initial begin
    for (int i = 0; i < 1024; i++) gold[i] = 32'hA500_0000 | i;
    m_v = '{1'b0, 1'b0}; m_d = '{32'd0, 32'd0}; m_e = '{1'b0, 1'b0};
    m_prio = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      a_rdy = '{pe1_req_ready, pe2_req_ready};
      a_we  = '{mem_we1, mem_we2};
      a_a   = '{mem_a1, mem_a2};
      a_wd  = '{mem_wd1, mem_wd2};
      a_rv  = '{pe1_rsp_valid, pe2_rsp_valid};
      a_rd  = '{pe1_rsp_rdata, pe2_rsp_rdata};
      a_re  = '{pe1_rsp_err, pe2_rsp_err};
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("rst_req_ready%0d", k+1), a_rdy[k], 0);
          chk($sformatf("rst_mem_we%0d", k+1), a_we[k], 0);
          chk($sformatf("rst_rsp_valid%0d", k+1), a_rv[k], 0);
          chk($sformatf("rst_rsp_rdata%0d", k+1), a_rd[k], 0);
          chk($sformatf("rst_rsp_err%0d", k+1), a_re[k], 0);
        end
        chk("rst_conflict_cnt", conflict_cnt, 0);
        m_v = '{1'b0, 1'b0}; m_prio = 0; m_cnt = 0;
      end else begin
        v  = '{pe1_req_valid, pe2_req_valid};
        we = '{pe1_req_we, pe2_req_we};
        ad = '{pe1_req_addr, pe2_req_addr};
        wd = '{pe1_req_wdata, pe2_req_wdata};
        rr = '{pe1_rsp_ready, pe2_rsp_ready};
        for (int k = 0; k < 2; k++) begin
          e[k]  = (ad[k] % 4 != 0) || (ad[k] >= 32'd4096);
          w[k]  = int'((ad[k] / 4) % 1024);
          fr[k] = !m_v[k] || rr[k];
        end
        conf = v[0] && v[1] && fr[0] && fr[1] && !e[0] && !e[1] &&
               (w[0] == w[1]) && (we[0] || we[1]);
        for (int k = 0; k < 2; k++) begin
          rdy[k] = fr[k] && !(conf && m_prio != k);
          acc[k] = v[k] && rdy[k];
          chk($sformatf("req_ready%0d", k+1), a_rdy[k], rdy[k]);
          chk($sformatf("mem_we%0d", k+1), a_we[k], acc[k] && we[k] && !e[k]);
          chk($sformatf("mem_a%0d", k+1), a_a[k], v[k] ? w[k] : 0);
          if (acc[k] && we[k] && !e[k]) chk($sformatf("mem_wd%0d", k+1), a_wd[k], wd[k]);
          chk($sformatf("rsp_valid%0d", k+1), a_rv[k], m_v[k]);
          if (m_v[k]) begin
            chk($sformatf("rsp_rdata%0d", k+1), a_rd[k], m_d[k]);
            chk($sformatf("rsp_err%0d", k+1), a_re[k], m_e[k]);
          end
        end
        chk("conflict_cnt", conflict_cnt, m_cnt);
        for (int k = 0; k < 2; k++) begin
          if (acc[k]) begin
            m_v[k] = 1'b1;
            m_e[k] = e[k];
            m_d[k] = (!we[k] && !e[k]) ? gold[w[k]] : 32'd0;
          end else if (rr[k]) begin
            m_v[k] = 1'b0;
          end
        end
        for (int k = 0; k < 2; k++)
          if (acc[k] && we[k] && !e[k]) gold[w[k]] = wd[k];
        if (conf) begin
          m_prio = 1 - m_prio;
          if (m_cnt != 65535) m_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int pe, input logic vv, input logic ww,
                         input logic [31:0] a, input logic [31:0] d);
    if (pe == 1) begin
      pe1_req_valid = vv; pe1_req_we = ww; pe1_req_addr = a; pe1_req_wdata = d;
    end else begin
      pe2_req_valid = vv; pe2_req_we = ww; pe2_req_addr = a; pe2_req_wdata = d;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r < 11)      return 32'h300 + 4 * $urandom_range(0, 3);
    else if (r < 13) return 32'h300 + $urandom_range(1, 3);
    else if (r < 14) return 32'h1300 + 4 * $urandom_range(0, 3);
    else             return 4 * $urandom_range(0, 1023);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic hs1, hs2;

  initial begin
    rst = 1'b0;
    set_req(1, 0, 0, 0, 0);
    set_req(2, 0, 0, 0, 0);
    pe1_rsp_ready = 1'b1;
    pe2_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Basic store then load.
    set_req(1, 1, 1, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    chk("basic_st_ready", pe1_req_ready, 1);
    chk("basic_we1", mem_we1, 1);
    chk("basic_a1", mem_a1, 16);
    step(); set_req(1, 1, 0, 32'h40, 0);
    @(negedge clk);
    chk("basic_st_ack", pe1_rsp_valid, 1);
    chk("basic_ld_we1", mem_we1, 0);
    step(); set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("basic_ld_valid", pe1_rsp_valid, 1);
    chk("basic_ld_rdata", pe1_rsp_rdata, 32'hDEADBEEF);

    // Same-word store/store, prio = PE1.
    step(); set_req(1, 1, 1, 32'h80, 32'h11); set_req(2, 1, 1, 32'h80, 32'h22);
    @(negedge clk);
    chk("ss_ready1", pe1_req_ready, 1);
    chk("ss_ready2", pe2_req_ready, 0);
    chk("ss_we1", mem_we1, 1);
    chk("ss_we2", mem_we2, 0);
    chk("ss_wd1", mem_wd1, 32'h11);
    step(); set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("ss_retry_ready2", pe2_req_ready, 1);
    chk("ss_retry_we2", mem_we2, 1);
    chk("ss_retry_a2", mem_a2, 32);
    step(); set_req(2, 0, 0, 0, 0); set_req(1, 1, 0, 32'h80, 0);
    @(negedge clk);
    step(); set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("ss_load_rdata", pe1_rsp_rdata, 32'h22);
    chk("ss_cnt", conflict_cnt, 1);
    // prio now names PE2.
    step(); set_req(1, 1, 1, 32'h84, 32'h33); set_req(2, 1, 1, 32'h84, 32'h44);
    @(negedge clk);
    chk("ss2_ready2", pe2_req_ready, 1);
    chk("ss2_ready1", pe1_req_ready, 0);
    step(); set_req(2, 0, 0, 0, 0);
    @(negedge clk);
    chk("ss2_retry_we1", mem_we1, 1);
    step(); set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("ss2_cnt", conflict_cnt, 2);

    // Read-read same word.
    step(); set_req(1, 1, 0, 32'h100, 0); set_req(2, 1, 0, 32'h100, 0);
    @(negedge clk);
    chk("rr_ready1", pe1_req_ready, 1);
    chk("rr_ready2", pe2_req_ready, 1);
    step(); set_req(1, 0, 0, 0, 0); set_req(2, 0, 0, 0, 0);
    @(negedge clk);
    chk("rr_rdata1", pe1_rsp_rdata, 32'hA500_0040);
    chk("rr_rdata2", pe2_rsp_rdata, 32'hA500_0040);
    chk("rr_cnt", conflict_cnt, 2);

    // Different words, store and load together.
    step(); set_req(1, 1, 1, 32'h200, 32'h55); set_req(2, 1, 0, 32'h204, 0);
    @(negedge clk);
    chk("dw_ready1", pe1_req_ready, 1);
    chk("dw_ready2", pe2_req_ready, 1);
    chk("dw_a1", mem_a1, 32'h80);
    chk("dw_a2", mem_a2, 32'h81);
    step(); set_req(1, 0, 0, 0, 0); set_req(2, 0, 0, 0, 0);
    @(negedge clk);
    chk("dw_rdata2", pe2_rsp_rdata, 32'hA500_0081);

    // Error requests.
    step(); set_req(2, 1, 0, 32'h102, 0);
    @(negedge clk);
    chk("mis_ready2", pe2_req_ready, 1);
    chk("mis_we2", mem_we2, 0);
    step(); set_req(2, 1, 0, 32'h1000, 0);
    @(negedge clk);
    chk("mis_err2", pe2_rsp_err, 1);
    chk("mis_rdata2", pe2_rsp_rdata, 0);
    step(); set_req(2, 1, 1, 32'h1000, 32'hBAD);
    @(negedge clk);
    chk("oor_err2", pe2_rsp_err, 1);
    chk("oor_rdata2", pe2_rsp_rdata, 0);
    chk("oor_st_we2", mem_we2, 0);
    step(); set_req(2, 0, 0, 0, 0); set_req(1, 1, 0, 32'h0, 0);
    @(negedge clk);
    chk("oor_st_err2", pe2_rsp_err, 1);
    step(); set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("oor_word0_intact", pe1_rsp_rdata, 32'hA500_0000);

    // Backpressure on PE1 response.
    step(); pe1_rsp_ready = 1'b0; set_req(1, 1, 0, 32'h40, 0);
    @(negedge clk);
    chk("bp_first_ready", pe1_req_ready, 1);
    step(); set_req(1, 1, 0, 32'h200, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_ready", pe1_req_ready, 0);
      chk("bp_hold_rdata", pe1_rsp_rdata, 32'hDEADBEEF);
      if (k < 2) step();
    end
    step(); pe1_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", pe1_req_ready, 1);
    step(); set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_second_rdata", pe1_rsp_rdata, 32'h55);

    // Reset with both responses outstanding.
    step(); set_req(1, 1, 0, 32'h40, 0); set_req(2, 1, 0, 32'h200, 0);
    @(negedge clk);
    step(); set_req(1, 0, 0, 0, 0); set_req(2, 0, 0, 0, 0);
    pe1_rsp_ready = 1'b0; pe2_rsp_ready = 1'b0;
    #1;
    chk("pre_rst_valid1", pe1_rsp_valid, 1);
    chk("pre_rst_valid2", pe2_rsp_valid, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_valid1", pe1_rsp_valid, 0);
    chk("async_rst_valid2", pe2_rsp_valid, 0);
    chk("async_rst_rdata1", pe1_rsp_rdata, 0);
    chk("async_rst_cnt", conflict_cnt, 0);
    chk("async_rst_ready1", pe1_req_ready, 0);
    step(); rst = 1'b1; pe1_rsp_ready = 1'b1; pe2_rsp_ready = 1'b1;
    set_req(1, 1, 1, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    chk("post_rst_we1", mem_we1, 1);
    chk("post_rst_a1", mem_a1, 16);
    step(); set_req(1, 1, 0, 32'h40, 0);
    @(negedge clk);
    step(); set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_rdata", pe1_rsp_rdata, 32'hCAFEF00D);
    step(); set_req(1, 1, 1, 32'h88, 32'h1); set_req(2, 1, 1, 32'h88, 32'h2);
    @(negedge clk);
    chk("post_rst_prio_ready1", pe1_req_ready, 1);
    chk("post_rst_prio_ready2", pe2_req_ready, 0);
    step(); set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    step(); set_req(2, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_cnt", conflict_cnt, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      hs1 = pe1_req_valid && pe1_req_ready;
      hs2 = pe2_req_valid && pe2_req_ready;
      step();
      if (hs1 || !pe1_req_valid)
        set_req(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom);
      if (hs2 || !pe2_req_valid)
        set_req(2, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom);
      pe1_rsp_ready = $urandom_range(0, 3) != 0;
      pe2_rsp_ready = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_pe_mem_ctrl.md
# dual_pe_mem_ctrl

Request-side controller for the dual-ported 1024 x 32 data memory shared by PE1 and PE2. It accepts load/store requests from each PE over a valid/ready handshake and checks alignment and range. It drives the memory's two write-enable/address/write-data port pairs and returns read data, or a store acknowledge, one cycle later through a registered response slot per PE. Same-word accesses in one cycle where at least one is a write are serialized with round-robin priority, so the memory never sees a write collision.

## Interface
- DATA_W, 32, data width of PE and memory ports
- DEPTH, 1024, memory depth in words; byte range is 0 .. 4*DEPTH-1
- CNT_W, 16, width of the conflict counter
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- peN_req_valid  in  1  request valid (N = 1, 2; all peN_ ports duplicated)
- peN_req_ready  out  1  request accepted when valid && ready
- peN_req_we  in  1  1 = store, 0 = load
- peN_req_addr  in  32  byte address
- peN_req_wdata  in  DATA_W  store data
- peN_rsp_valid  out  1  response valid
- peN_rsp_ready  in  1  response consumed when valid && ready
- peN_rsp_rdata  out  DATA_W  load data; 0 for stores and errors
- peN_rsp_err  out  1  misaligned or out-of-range request
- mem_weN  out  1  memory write enable, port N
- mem_aN  out  32  memory word address, port N (zero-extended word index)
- mem_wdN  out  DATA_W  memory write data, port N
- mem_rdN  in  DATA_W  memory combinational read data, port N
- conflict_cnt  out  CNT_W  saturating count of serialized conflicts

## Operation
- A request is in error if addr[1:0] != 0 or addr >= 4*DEPTH. An error request is accepted normally, never asserts mem_weN, and responds with rdata = 0, err = 1.
- Word index is addr[11:2]. mem_aN = index of the pending request whenever peN_req_valid = 1; otherwise 0. mem_wdN = peN_req_wdata.
- mem_weN = accepted && we && !err, in the acceptance cycle only.
- Slot-free condition: peN_rsp_valid = 0, or peN_rsp_ready = 1 in the same cycle.
- peN_req_ready = rst && slot free && !(conflict && this PE loses).
- Conflict: both PEs valid, both slots free, neither request in error, equal word index, and at least one is a store. Read-read to the same word is not a conflict; both are served.
- Priority register prio (0 = PE1, 1 = PE2). On a conflict the PE named by prio wins, and prio then flips to the loser. With no conflict, prio holds. The loser retries unchanged and is served in the next cycle.
- Response: on acceptance, the slot loads rdata = mem_rdN (load, no error) or 0, loads err, and sets rsp_valid. The slot clears on rsp_ready unless a new acceptance reloads it in the same cycle.
- A load accepted in the same cycle as the other PE's store to a different word sees the memory's pre-edge contents. Same-word load/store is always serialized.
- conflict_cnt increments once per conflict cycle and saturates at all-ones.

## Timing
- Reset (rst = 0, asynchronous) values:
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - prio = 0, conflict_cnt = 0
  - req_ready = 0, mem_weN = 0
- Request to mem port signals is combinational. The response is registered at the acceptance edge, so rsp_valid rises 1 cycle after acceptance.
- Throughput is 1 request per PE per cycle when the response is consumed every cycle.
- A conflicted loser sees 1 stall cycle. Repeated conflicts alternate winners, so neither PE waits more than 1 cycle per conflict.
- If rst asserts mid-transfer, responses in flight are dropped. A store accepted on that edge still writes, because the memory is not reset.

## Structure
- Package dual_pe_mem_pkg holds:
  - DEPTH, IDX_W = $clog2(DEPTH)
  - the request struct (we, addr, wdata)
  - function addr_err(addr) and function word_idx(addr)
- Sub-module pe_rsp_slot: one-entry response register with slot-free logic, instantiated twice.
- The top holds the conflict detection, prio register, mem port muxing and conflict_cnt.

## Test plan
- Basic access: PE1 stores 0xDEADBEEF to 0x40, then loads 0x40. Required response: mem_we1 pulses with mem_a1 = 16, and the load rsp_rdata = 0xDEADBEEF one cycle after acceptance.
- Same-word store/store: both PEs store to 0x80 in one cycle (PE1 0x11, PE2 0x22) with prio = 0. PE1 writes first and PE2 writes the next cycle. A following load returns 0x22, conflict_cnt = 1 and prio = 1.
- Read-read and different-word cases:
  - both PEs load 0x100 in one cycle: both accepted, no stall, conflict_cnt unchanged
  - PE1 stores 0x200 while PE2 loads 0x204 in one cycle: both accepted in that cycle
- Error requests:
  - PE2 loads 0x102 (misaligned): accepted, mem_we2 = 0, rsp_err = 1, rdata = 0
  - PE2 loads 0x1000 (out of range): same response
- Backpressure: PE1 rsp_ready held low for 3 cycles with a second request pending. Required response: req_ready stays 0 until the first response is consumed, then the second request is accepted in that same cycle.
- Reset mid-stream: assert rst low while both rsp_valid = 1. All outputs take their reset values asynchronously. After release, the first request behaves as in the basic access test, with prio = 0.
